stopwatch_ctrl: RTL and testbench

Run/pause/lap/clear controller for the stopwatch datapath. It sequences a clock prescaler and a minutes:seconds counter pair from two front-panel pulse inputs, start/stop and lap/clear. It captures lap times into a holding register and reports wrap-around. It sits between the debounced button logic and the display driver.

---
 rtl/stopwatch_ctrl.sv | 156 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear sequencer for a mm:ss stopwatch.
// Ports: i_clk, i_rstn (sync, active-low), i_start_stop, i_lap_clr pulses in;
//   o_state, o_sec, o_min, o_lap_sec, o_lap_min, o_lap_valid, o_tick, o_wrap out.
// Option: STOPWATCH_AUTOSTOP_EN pauses at MAX_MIN:59 instead of wrapping.
module stopwatch_ctrl #(
    parameter int CLK2SEC = 10,
    parameter int MAX_MIN = 59
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_start_stop,
    input  logic       i_lap_clr,
    output logic [1:0] o_state,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [5:0] o_lap_sec,
    output logic [5:0] o_lap_min,
    output logic       o_lap_valid,
    output logic       o_tick,
    output logic       o_wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(CLK2SEC - 1);
    localparam logic [5:0]  MIN_LAST   = 6'(MAX_MIN);

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [5:0]  sec_q, sec_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  lap_sec_q, lap_sec_d;
    logic [5:0]  lap_min_q, lap_min_d;
    logic        lap_valid_q, lap_valid_d;
    logic        tick_q, tick_d;
    logic        wrap_q, wrap_d;
    // Set once the count has stopped at the top value, so the next
    // second after resuming rolls over to 00:00 instead of stopping again.
    logic        held_q, held_d;

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        sec_d       = sec_q;
        min_d       = min_q;
        lap_sec_d   = lap_sec_q;
        lap_min_d   = lap_min_q;
        lap_valid_d = lap_valid_q;
        held_d      = held_q;
        tick_d      = 1'b0;
        wrap_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                presc_d     = '0;
                sec_d       = '0;
                min_d       = '0;
                lap_sec_d   = '0;
                lap_min_d   = '0;
                lap_valid_d = 1'b0;
                held_d      = 1'b0;
                if (i_start_stop) state_d = S_RUN;
            end
            S_RUN: begin
                // Lap samples the pre-edge count, even on a second boundary.
                if (i_lap_clr) begin
                    lap_sec_d   = sec_q;
                    lap_min_d   = min_q;
                    lap_valid_d = 1'b1;
                end
                if (i_start_stop) state_d = S_PAUSE;
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == MIN_LAST) begin
                            wrap_d = 1'b1;
                            min_d  = '0;
                            held_d = 1'b0;
`ifdef STOPWATCH_AUTOSTOP_EN
                            if (!held_q) begin
                                sec_d   = sec_q;
                                min_d   = min_q;
                                tick_d  = 1'b0;
                                held_d  = 1'b1;
                                state_d = S_PAUSE;
                            end
`endif
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end
            S_PAUSE: begin
                if (i_lap_clr) begin
                    state_d     = S_IDLE;
                    presc_d     = '0;
                    sec_d       = '0;
                    min_d       = '0;
                    lap_sec_d   = '0;
                    lap_min_d   = '0;
                    lap_valid_d = 1'b0;
                    held_d      = 1'b0;
                end else if (i_start_stop) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_valid_q <= 1'b0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            lap_sec_q   <= lap_sec_d;
            lap_min_q   <= lap_min_d;
            lap_valid_q <= lap_valid_d;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
            held_q      <= held_d;
        end
    end

    assign o_state     = state_q;
    assign o_sec       = sec_q;
    assign o_min       = min_q;
    assign o_lap_sec   = lap_sec_q;
    assign o_lap_min   = lap_min_q;
    assign o_lap_valid = lap_valid_q;
    assign o_tick      = tick_q;
    assign o_wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed + random checks of stopwatch_ctrl
// against an elapsed-run-cycle reference model.
module tb_stopwatch_ctrl;

    localparam int C  = 10;
    localparam int MM = 1;
    localparam int P  = 60 * (MM + 1);

    logic       clk = 1'b0;
    logic       i_rstn, i_start_stop, i_lap_clr;
    logic [1:0] o_state;
    logic [5:0] o_sec, o_min, o_lap_sec, o_lap_min;
    logic       o_lap_valid, o_tick, o_wrap;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.CLK2SEC(C), .MAX_MIN(MM)) dut (
        .i_clk(clk),
        .i_rstn(i_rstn),
        .i_start_stop(i_start_stop),
        .i_lap_clr(i_lap_clr),
        .o_state(o_state),
        .o_sec(o_sec),
        .o_min(o_min),
        .o_lap_sec(o_lap_sec),
        .o_lap_min(o_lap_min),
        .o_lap_valid(o_lap_valid),
        .o_tick(o_tick),
        .o_wrap(o_wrap)
    );

    int tests = 0;
    int fails = 0;

    // Model: t = RUN cycles elapsed since clear (modulo the full period).
    int m_state = 0;
    int t = 0;
    int m_lsec = 0, m_lmin = 0;
    int m_lv = 0, m_tick = 0, m_wrap = 0, m_held = 0;

    function automatic int m_sec();
        return (t / C) % 60;
    endfunction

    function automatic int m_min();
        return (t / C) / 60;
    endfunction

    task automatic m_clear();
        t = 0; m_lsec = 0; m_lmin = 0; m_lv = 0; m_held = 0;
    endtask

    task automatic model(input bit ss, input bit lc, input bit rn);
        int tn;
        m_tick = 0;
        m_wrap = 0;
        if (!rn) begin
            m_state = 0;
            m_clear();
        end else if (m_state == 0) begin
            if (ss) m_state = 1;
        end else if (m_state == 1) begin
            if (lc) begin
                m_lsec = m_sec(); m_lmin = m_min(); m_lv = 1;
            end
            if (ss) m_state = 2;
            tn = t + 1;
            if (tn % C == 0) m_tick = 1;
            if (tn == P * C) begin
                m_wrap = 1;
`ifdef STOPWATCH_AUTOSTOP_EN
                if (!m_held) begin
                    m_tick = 0; m_held = 1; m_state = 2;
                    tn = (P - 1) * C;
                end else begin
                    m_held = 0; tn = 0;
                end
`else
                tn = 0;
`endif
            end
            t = tn;
        end else begin
            if (lc) begin
                m_state = 0; m_clear();
            end else if (ss) begin
                m_state = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("state", 32'(o_state), m_state);
        chk("sec", 32'(o_sec), m_sec());
        chk("min", 32'(o_min), m_min());
        chk("lap_sec", 32'(o_lap_sec), m_lsec);
        chk("lap_min", 32'(o_lap_min), m_lmin);
        chk("lap_valid", 32'(o_lap_valid), m_lv);
        chk("tick", 32'(o_tick), m_tick);
        chk("wrap", 32'(o_wrap), m_wrap);
    endtask

    task automatic cyc(input bit ss, input bit lc, input bit rn);
        i_start_stop = ss;
        i_lap_clr    = lc;
        i_rstn       = rn;
        @(posedge clk);
        model(ss, lc, rn);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_to_sec(input int s);
        for (int k = 0; k < 2000; k++) begin
            if (m_state == 1 && m_sec() == s) break;
            cyc(1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        i_rstn = 1'b0;
        i_start_stop = 1'b0;
        i_lap_clr = 1'b0;
        @(negedge clk);
        // Reset then start, count a few seconds
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        idle(30);
        // Pause with prescaler held at 4, long hold, resume
        for (int k = 0; k < 20 && t % C != 3; k++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        idle(50);
        cyc(1'b1, 1'b0, 1'b1);
        idle(12);
        // Lap at 0:07, keep counting, pause then clear
        run_to_sec(7);
        cyc(1'b0, 1'b1, 1'b1);
        idle(15);
        cyc(1'b1, 1'b0, 1'b1);
        idle(5);
        cyc(1'b0, 1'b1, 1'b1);
        idle(3);
        // Both pulses in RUN, then both in PAUSE
        cyc(1'b1, 1'b0, 1'b1);
        run_to_sec(4);
        cyc(1'b1, 1'b1, 1'b1);
        idle(3);
        cyc(1'b1, 1'b1, 1'b1);
        idle(3);
        // Free run through the full-period wrap
        cyc(1'b1, 1'b0, 1'b1);
        idle(P * C + 15);
        // Lap then reset mid-RUN with a simultaneous start
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        idle(3);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        run_to_sec(5);
        cyc(1'b0, 1'b1, 1'b1);
        idle(2);
        cyc(1'b1, 1'b0, 1'b0);
        idle(3);
        // Random pulse traffic
        for (int k = 0; k < 1500; k++) begin
            cyc($urandom_range(0, 19) == 0,
                $urandom_range(0, 24) == 0,
                $urandom_range(0, 299) != 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
